// File: rtl/mult_issue_unit.sv
// -----------------------------------------------------------------------------
// mult_issue_unit
//
// Execute-stage front end for the Dadda multiplier. Accepts an M-extension
// multiply request from EX, launches one multiplier operation, stalls EX while
// that operation is in flight, captures the result on the multiplier's ready
// pulse and hands it to writeback. A one-entry result cache answers an exact
// repeat (same op and operands) of the last completed operation without
// relaunching the multiplier.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     EX request handshake
//   req_op/rs1/rs2/rd       multiply kind (mul/mulh/mulhsu/mulhu), operands, dest tag
//   flush                   squash in-flight or pending result
//   mult_start              one-cycle launch pulse to the multiplier
//   mult_op/rs1/rs2         operation and operands held from launch to completion
//   mult_rdy/mult_result    multiplier completion pulse and result
//   rsp_valid/rsp_ready     writeback handshake
//   rsp_data/rsp_rd         result and its destination tag
//   ex_stall                EX must hold
//   err_timeout             one-cycle pulse when the multiplier never answered
// -----------------------------------------------------------------------------
module mult_issue_unit #(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [4:0]      req_rd,
    input  logic            flush,
    output logic            mult_start,
    output logic [2:0]      mult_op,
    output logic [XLEN-1:0] mult_rs1,
    output logic [XLEN-1:0] mult_rs2,
    input  logic            mult_rdy,
    input  logic [XLEN-1:0] mult_result,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic [4:0]      rsp_rd,
    output logic            ex_stall,
    output logic            err_timeout
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t          state_q;
    logic [1:0]      op_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [4:0]      rd_q;
    logic            dead_q;
    logic [CW-1:0]   wait_cnt_q;
    logic            mult_start_q;
    logic            rsp_valid_q;
    logic [XLEN-1:0] rsp_data_q;
    logic [4:0]      rsp_rd_q;
    logic            err_timeout_q;
    logic            cache_v_q;
    logic [1:0]      cache_op_q;
    logic [XLEN-1:0] cache_rs1_q;
    logic [XLEN-1:0] cache_rs2_q;
    logic [XLEN-1:0] cache_data_q;

    // Exact match of a request against the single cached operation.
    function automatic logic cache_hit(
        input logic            v,
        input logic [1:0]      c_op,
        input logic [XLEN-1:0] c_rs1,
        input logic [XLEN-1:0] c_rs2,
        input logic [1:0]      r_op,
        input logic [XLEN-1:0] r_rs1,
        input logic [XLEN-1:0] r_rs2
    );
        return v && (c_op == r_op) && (c_rs1 == r_rs1) && (c_rs2 == r_rs2);
    endfunction

    // Issue FSM: request capture, launch, completion/timeout, response and result cache.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            op_q          <= 2'b00;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= 5'd0;
            dead_q        <= 1'b0;
            wait_cnt_q    <= '0;
            mult_start_q  <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_rd_q      <= 5'd0;
            err_timeout_q <= 1'b0;
            cache_v_q     <= 1'b0;
            cache_op_q    <= 2'b00;
            cache_rs1_q   <= '0;
            cache_rs2_q   <= '0;
            cache_data_q  <= '0;
        end else begin
            // Pulses default low; the state arms below raise them for one cycle.
            mult_start_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid && !flush) begin
                        op_q   <= req_op;
                        rs1_q  <= req_rs1;
                        rs2_q  <= req_rs2;
                        rd_q   <= req_rd;
                        dead_q <= 1'b0;
                        if (cache_hit(cache_v_q, cache_op_q, cache_rs1_q, cache_rs2_q,
                                      req_op, req_rs1, req_rs2)) begin
                            rsp_data_q  <= cache_data_q;
                            rsp_rd_q    <= req_rd;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else begin
                            mult_start_q <= 1'b1;
                            state_q      <= S_LAUNCH;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_LAUNCH: begin
                    // The multiplier cannot abort, so a flush here only kills the result.
                    wait_cnt_q <= '0;
                    state_q    <= S_WAIT;
                    if (flush) begin
                        dead_q <= 1'b1;
                    end else begin
                        dead_q <= dead_q;
                    end
                end
                S_WAIT: begin
                    if (mult_rdy) begin
                        // A completed result always refreshes the cache, even when squashed.
                        cache_v_q    <= 1'b1;
                        cache_op_q   <= op_q;
                        cache_rs1_q  <= rs1_q;
                        cache_rs2_q  <= rs2_q;
                        cache_data_q <= mult_result;
                        if (dead_q || flush) begin
                            state_q <= S_IDLE;
                        end else begin
                            rsp_data_q  <= mult_result;
                            rsp_rd_q    <= rd_q;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end
                    end else if (wait_cnt_q == CNT_LAST) begin
                        // Abandon the operation; a late answer must not be trusted.
                        err_timeout_q <= 1'b1;
                        cache_v_q     <= 1'b0;
                        state_q       <= S_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CW'(1);
                        if (flush) begin
                            dead_q <= 1'b1;
                        end else begin
                            dead_q <= dead_q;
                        end
                    end
                end
                S_RESP: begin
                    // Flush wins over a same-cycle rsp_ready: the result counts as undelivered.
                    if (flush || rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        state_q <= S_RESP;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake-dependent outputs must react within the cycle; rst_n forces them low.
    assign req_ready = rst_n && (state_q == S_IDLE) && !flush;
    assign ex_stall  = rst_n && ((state_q == S_LAUNCH) ||
                                 (state_q == S_WAIT) ||
                                 ((state_q == S_RESP) && !rsp_ready) ||
                                 ((state_q == S_IDLE) && req_valid && !flush));

    assign mult_start  = mult_start_q;
    assign mult_op     = {1'b0, op_q};
    assign mult_rs1    = rs1_q;
    assign mult_rs2    = rs2_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_rd      = rsp_rd_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_mult_issue_unit.sv
module tb_mult_issue_unit;

    localparam int XLEN = 32;
    localparam int TO   = 15;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [31:0]     req_rs1;
    logic [31:0]     req_rs2;
    logic [4:0]      req_rd;
    logic            flush;
    logic            mult_start;
    logic [2:0]      mult_op;
    logic [31:0]     mult_rs1;
    logic [31:0]     mult_rs2;
    logic            mult_rdy;
    logic [31:0]     mult_result;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_data;
    logic [4:0]      rsp_rd;
    logic            ex_stall;
    logic            err_timeout;

    always #5 clk = ~clk;

    mult_issue_unit #(.XLEN(XLEN), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .flush(flush),
        .mult_start(mult_start), .mult_op(mult_op), .mult_rs1(mult_rs1), .mult_rs2(mult_rs2),
        .mult_rdy(mult_rdy), .mult_result(mult_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
        .ex_stall(ex_stall), .err_timeout(err_timeout)
    );

    int total = 0;
    int bad   = 0;

    // Multiplier model state; mdl_delay 0 means the multiplier never answers.
    int          mdl_delay = 2;
    int          mdl_cnt;
    int          starts;
    logic [1:0]  m_op;
    logic [31:0] m_a, m_b;

    // Reference cache: the last completed op/operands.
    logic        bc_v = 1'b0;
    logic [1:0]  bc_op;
    logic [31:0] bc_a, bc_b;

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, ps;
        longint unsigned ua, ub, pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            2'b00:   begin pu = ua * ub;           return pu[31:0];  end
            2'b01:   begin ps = sa * sb;           return ps[63:32]; end
            2'b10:   begin ps = sa * longint'(ub); return ps[63:32]; end
            default: begin pu = ua * ub;           return pu[63:32]; end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Multiplier model: answers mdl_delay cycles after the start cycle.
    initial begin
        mult_rdy    = 1'b0;
        mult_result = 32'h0;
        mdl_cnt     = 0;
        starts      = 0;
        forever begin
            @(posedge clk);
            #1;
            mult_rdy    = 1'b0;
            mult_result = $urandom();
            if (mdl_cnt > 0) begin
                mdl_cnt--;
                if (mdl_cnt == 0) begin
                    mult_rdy    = 1'b1;
                    mult_result = ref_mul(m_op, m_a, m_b);
                end
            end
            if (mult_start === 1'b1) begin
                starts++;
                m_op    = mult_op[1:0];
                m_a     = mult_rs1;
                m_b     = mult_rs2;
                mdl_cnt = mdl_delay;
            end
        end
    end

    // One full request/response transaction with latency, hit and hold checks.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int dly, input int hold);
        logic        hit;
        logic [31:0] expd;
        int          s0;
        int          n;
        expd = ref_mul(op, a, b);
        hit  = bc_v && (bc_op == op) && (bc_a == a) && (bc_b == b);
        mdl_delay = dly;
        next();
        req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
        #1;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        chk("stall_on_req", 32'(ex_stall), 32'd1);
        s0 = starts;
        next();
        req_valid = 1'b0; req_op = 2'($urandom()); req_rs1 = $urandom(); req_rs2 = $urandom(); req_rd = 5'($urandom());
        #1;
        if (hit) begin
            chk("hit_no_start", 32'(mult_start), 32'd0);
            chk("hit_rsp_next", 32'(rsp_valid), 32'd1);
        end else begin
            chk("miss_start", 32'(mult_start), 32'd1);
            n = 0;
            while (rsp_valid !== 1'b1 && n < 40) begin
                next();
                #1;
                n++;
                chk("stall_busy", 32'(ex_stall), 32'd1);
                chk("no_timeout", 32'(err_timeout), 32'd0);
            end
            chk("miss_latency", 32'(n), 32'(dly + 1));
            chk("held_op", 32'(mult_op), 32'({1'b0, op}));
            chk("held_rs1", mult_rs1, a);
            chk("held_rs2", mult_rs2, b);
        end
        chk("start_count", 32'(starts - s0), hit ? 32'd0 : 32'd1);
        for (int i = 0; i < hold; i++) begin
            chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_hold_data", rsp_data, expd);
            chk("rsp_hold_stall", 32'(ex_stall), 32'd1);
            next();
            #1;
        end
        rsp_ready = 1'b1;
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_data", rsp_data, expd);
        chk("rsp_rd", 32'(rsp_rd), 32'(rd));
        chk("stall_release", 32'(ex_stall), 32'd0);
        next();
        rsp_ready = 1'b0;
        #1;
        chk("rsp_dropped", 32'(rsp_valid), 32'd0);
        chk("back_idle", 32'(req_ready), 32'd1);
        bc_v = 1'b1; bc_op = op; bc_a = a; bc_b = b;
    endtask

    // Issue a request and step until its launch cycle (checks the start pulse).
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int dly);
        mdl_delay = dly;
        next();
        req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = 5'd9;
        next();
        req_valid = 1'b0;
        #1;
        chk("launch_start", 32'(mult_start), 32'd1);
    endtask

    initial begin
        int          n;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_rs1 = 32'h0; req_rs2 = 32'h0;
        req_rd = 5'd0; flush = 1'b0; rsp_ready = 1'b0;
        #3;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mult_start", 32'(mult_start), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_stall", 32'(ex_stall), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic miss, hold, hit, relaunch and the timeout/ready tie.
        do_op(2'b00, 32'd7, 32'd6, 5'd3, 2, 0);
        do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 2, 3);
        do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 2, 0);
        do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd6, 3, 1);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, TO, 0);

        // Flush during WAIT: no response, result still fills the cache.
        launch(2'b01, 32'hFFFF_FFF9, 32'd13, 4);
        next();
        flush = 1'b1;
        #1;
        chk("flush_wait_stall", 32'(ex_stall), 32'd1);
        chk("flush_wait_noready", 32'(req_ready), 32'd0);
        next();
        flush = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("flush_no_rsp", 32'(rsp_valid), 32'd0);
            next();
        end
        #1;
        chk("flush_idle_ready", 32'(req_ready), 32'd1);
        bc_v = 1'b1; bc_op = 2'b01; bc_a = 32'hFFFF_FFF9; bc_b = 32'd13;
        do_op(2'b01, 32'hFFFF_FFF9, 32'd13, 5'd8, 4, 0);

        // Timeout: multiplier silent, pulse after TO WAIT cycles, cache invalidated.
        launch(2'b00, 32'd3, 32'd5, 0);
        n = 0;
        while (err_timeout !== 1'b1 && n < 40) begin
            next();
            #1;
            n++;
            chk("to_no_rsp", 32'(rsp_valid), 32'd0);
        end
        chk("to_latency", 32'(n), 32'(TO + 1));
        chk("to_idle", 32'(req_ready), 32'd1);
        next();
        #1;
        chk("to_pulse_end", 32'(err_timeout), 32'd0);
        bc_v = 1'b0;
        do_op(2'b01, 32'hFFFF_FFF9, 32'd13, 5'd10, 2, 0);

        // Flush and rsp_ready together in RESP: flush wins, response dropped.
        launch(2'b10, 32'd100, 32'd200, 1);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 10) begin
            next();
            #1;
            n++;
        end
        chk("fr_resp_reached", 32'(rsp_valid), 32'd1);
        flush = 1'b1; rsp_ready = 1'b1;
        next();
        flush = 1'b0; rsp_ready = 1'b0;
        #1;
        chk("fr_rsp_dropped", 32'(rsp_valid), 32'd0);
        chk("fr_idle", 32'(req_ready), 32'd1);
        bc_v = 1'b1; bc_op = 2'b10; bc_a = 32'd100; bc_b = 32'd200;

        // Random mix with frequent exact repeats.
        rop = 2'b00; ra = 32'd1; rb = 32'd1;
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 2) != 0) begin
                rop = 2'($urandom_range(0, 3));
                ra  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom();
                rb  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
            end
            do_op(rop, ra, rb, 5'($urandom()), $urandom_range(1, TO), $urandom_range(0, 3));
        end

        // Reset during WAIT: outputs drop at once, later stray mult_rdy ignored.
        launch(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 6);
        next();
        next();
        rst_n = 1'b0;
        #1;
        chk("arst_mult_start", 32'(mult_start), 32'd0);
        chk("arst_mult_op", 32'(mult_op), 32'd0);
        chk("arst_mult_rs1", mult_rs1, 32'd0);
        chk("arst_mult_rs2", mult_rs2, 32'd0);
        chk("arst_stall", 32'(ex_stall), 32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        next();
        rst_n = 1'b1;
        bc_v = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("stray_no_rsp", 32'(rsp_valid), 32'd0);
            chk("stray_no_start", 32'(mult_start), 32'd0);
            next();
        end
        do_op(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 5'd11, 3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
